// File: rtl/clk_rst_pkg.sv
// Shared types and default parameter values for the clock/reset controller.
package clk_rst_pkg;

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_STRETCH = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  localparam int DEF_DIV_WIDTH       = 8;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_STRETCH_CYCLES  = 16;
  localparam int DEF_DEBOUNCE_CYCLES = 50000;

endpackage

// File: rtl/clk_rst_ctrl_btn_debounce.sv
// Step-button conditioner: 2-flop synchronizer, stability counter,
// debounced level (idle high) and a one-cycle press pulse on 1->0.
module btn_debounce
  import clk_rst_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_ni,
  output logic level_o,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;
  logic          w_sync;
  logic          w_diff;
  logic          w_accept;

  assign w_sync   = r_sync[1];
  assign w_diff   = (w_sync != r_level);
  // The new level is taken on its DEBOUNCE_CYCLES-th consecutive sample.
  assign w_accept = w_diff && (r_cnt == CNT_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync  <= 2'b11;
      r_level <= 1'b1;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync  <= {r_sync[0], btn_ni};
      r_press <= w_accept && !w_sync;
      if (w_accept) begin
        r_level <= w_sync;
        r_cnt   <= '0;
      end else if (w_diff) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign level_o = r_level;
  assign press_o = r_press;

endmodule

// File: rtl/clk_rst_ctrl.sv
// Core clock-enable and reset sequencer: reset synchronizer, hold/stretch/run
// FSM, programmable tick divider and a debounced single-step mode.
module clk_rst_ctrl
  import clk_rst_pkg::*;
#(
  parameter int DIV_WIDTH       = DEF_DIV_WIDTH,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int STRETCH_CYCLES  = DEF_STRETCH_CYCLES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DIV_WIDTH-1:0] div_sel_i,
  input  logic                 mode_i,
  input  logic                 step_btn_ni,
  input  logic                 soft_rst_i,
  output logic                 tick_o,
  output logic                 core_rst_no,
  output logic [1:0]           state_o
);

  localparam int SCW = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
  localparam logic [SCW-1:0] STRETCH_LAST = SCW'(STRETCH_CYCLES - 1);

  state_t                 r_state;
  state_t                 w_state_next;
  logic [SYNC_STAGES-1:0] r_rst_sync;
  logic [1:0]             r_soft_sync;
  logic                   r_soft_prev;
  logic [SCW-1:0]         r_stretch_cnt;
  logic [SCW-1:0]         w_stretch_next;
  logic                   r_core_rst_n;
  logic                   r_mode_prev;
  logic [DIV_WIDTH-1:0]   r_div_cnt;
  logic [DIV_WIDTH-1:0]   r_div_n;
  logic [DIV_WIDTH-1:0]   w_div_cnt_next;
  logic [DIV_WIDTH-1:0]   w_div_n_next;
  logic                   r_tick;
  logic                   w_tick_next;
  logic                   w_rst_s;
  logic                   w_soft_rise;
  logic                   w_mode_chg;
  logic                   w_btn_level;
  logic                   w_btn_press;
  logic                   w_step;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .btn_ni (step_btn_ni),
    .level_o(w_btn_level),
    .press_o(w_btn_press)
  );

  assign w_rst_s     = r_rst_sync[SYNC_STAGES-1];
  assign w_soft_rise = r_soft_sync[1] && !r_soft_prev;
  assign w_mode_chg  = (mode_i != r_mode_prev);
  assign w_step      = w_btn_press && !w_btn_level;

  always_comb begin
    w_state_next   = r_state;
    w_stretch_next = r_stretch_cnt;
    case (r_state)
      S_HOLD: begin
        if (!w_rst_s) begin
          w_state_next   = S_STRETCH;
          w_stretch_next = '0;
        end
      end
      S_STRETCH: begin
        if (w_soft_rise) begin
          w_stretch_next = '0;
        end else if (r_stretch_cnt == STRETCH_LAST) begin
          w_state_next = S_RUN;
        end else begin
          w_stretch_next = r_stretch_cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (w_soft_rise) begin
          w_state_next   = S_STRETCH;
          w_stretch_next = '0;
        end
      end
      default: begin
        w_state_next   = S_HOLD;
        w_stretch_next = '0;
      end
    endcase
  end

  // Divider and tick: the divider is held clear outside STRETCH/RUN and on
  // any mode switch; N is only re-sampled when the count restarts.
  always_comb begin
    w_tick_next    = 1'b0;
    w_div_cnt_next = r_div_cnt;
    w_div_n_next   = r_div_n;
    if ((r_state != S_STRETCH) && (r_state != S_RUN)) begin
      w_div_cnt_next = '0;
      w_div_n_next   = div_sel_i;
    end else if (w_mode_chg) begin
      w_div_cnt_next = '0;
      w_div_n_next   = div_sel_i;
    end else if (!mode_i) begin
      if (r_div_cnt == r_div_n) begin
        w_div_cnt_next = '0;
        w_div_n_next   = div_sel_i;
        w_tick_next    = 1'b1;
      end else begin
        w_div_cnt_next = r_div_cnt + 1'b1;
      end
    end else begin
      w_div_cnt_next = '0;
      if (r_state == S_STRETCH) begin
        w_tick_next = 1'b1;
      end else begin
        w_tick_next = w_step && !w_soft_rise;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rst_sync    <= '1;
      r_soft_sync   <= 2'b00;
      r_soft_prev   <= 1'b0;
      r_state       <= S_HOLD;
      r_stretch_cnt <= '0;
      r_core_rst_n  <= 1'b0;
      r_mode_prev   <= 1'b0;
      r_div_cnt     <= '0;
      r_div_n       <= '0;
      r_tick        <= 1'b0;
    end else begin
      r_rst_sync    <= {r_rst_sync[SYNC_STAGES-2:0], 1'b0};
      r_soft_sync   <= {r_soft_sync[0], soft_rst_i};
      r_soft_prev   <= r_soft_sync[1];
      r_state       <= w_state_next;
      r_stretch_cnt <= w_stretch_next;
      r_core_rst_n  <= (w_state_next == S_RUN);
      r_mode_prev   <= mode_i;
      r_div_cnt     <= w_div_cnt_next;
      r_div_n       <= w_div_n_next;
      r_tick        <= w_tick_next;
    end
  end

  assign tick_o      = r_tick;
  assign core_rst_no = r_core_rst_n;
  assign state_o     = r_state;

endmodule

// File: tb/tb_clk_rst_ctrl.sv
// Scoreboard bench: stimulus queues expected state/reset/tick events by cycle,
// a negedge monitor pops and compares each event the DUT produces.
module tb_clk_rst_ctrl;

  localparam int K_STATE = 0;
  localparam int K_CORE  = 1;
  localparam int K_TICK  = 2;

  typedef struct {
    int kind;
    int cyc;
    int val;
  } ev_t;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] div_sel_i;
  logic       mode_i;
  logic       step_btn_ni;
  logic       soft_rst_i;
  logic       tick_o;
  logic       core_rst_no;
  logic [1:0] state_o;

  int  cyc = 0;
  int  tests = 0;
  int  fails = 0;
  ev_t exp_q[$];

  logic [1:0] prev_state = 2'd0;
  logic       prev_core  = 1'b0;

  clk_rst_ctrl #(
    .DIV_WIDTH      (8),
    .SYNC_STAGES    (2),
    .STRETCH_CYCLES (16),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .div_sel_i  (div_sel_i),
    .mode_i     (mode_i),
    .step_btn_ni(step_btn_ni),
    .soft_rst_i (soft_rst_i),
    .tick_o     (tick_o),
    .core_rst_no(core_rst_no),
    .state_o    (state_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  function automatic string kname(input int k);
    case (k)
      K_STATE: return "state";
      K_CORE:  return "core_rst_n";
      default: return "tick";
    endcase
  endfunction

  // Keep the queue ordered by cycle, then by the monitor's per-cycle order.
  function automatic void push_exp(input int kind, input int c, input int v);
    ev_t e;
    int  i;
    e.kind = kind;
    e.cyc  = c;
    e.val  = v;
    i = 0;
    while (i < exp_q.size() &&
           (exp_q[i].cyc < c || (exp_q[i].cyc == c && exp_q[i].kind <= kind)))
      i++;
    exp_q.insert(i, e);
  endfunction

  task automatic check_event(input int kind, input int v);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_%s: got %s=%0d at cycle %0d, expected no event",
               kname(kind), kname(kind), v, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.val != v) begin
        fails++;
        $display("FAIL event_%s: got %s=%0d at cycle %0d, expected %s=%0d at cycle %0d",
                 kname(e.kind), kname(kind), v, cyc, kname(e.kind), e.val, e.cyc);
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) begin
      @(posedge clk_i);
      #2;
    end
  endtask

  always @(negedge clk_i) begin
    if (state_o != prev_state) check_event(K_STATE, int'(state_o));
    if (core_rst_no != prev_core) check_event(K_CORE, int'(core_rst_no));
    if (tick_o) check_event(K_TICK, 1);
    prev_state = state_o;
    prev_core  = core_rst_no;
  end

  initial begin
    int b;
    int e1;
    int e2;
    rst_i       = 1'b0;
    div_sel_i   = 8'd255;
    mode_i      = 1'b0;
    step_btn_ni = 1'b1;
    soft_rst_i  = 1'b0;
    #1 rst_i = 1'b1;

    // Reset held 5 cycles, then release with a soft request landing in HOLD.
    wait_to(5);
    chk("reset_state", int'(state_o), 0);
    chk("reset_core_rst_n", int'(core_rst_no), 0);
    chk("reset_tick", int'(tick_o), 0);
    b = cyc;
    rst_i = 1'b0;
    soft_rst_i = 1'b1;
    push_exp(K_STATE, b + 3, 1);
    push_exp(K_STATE, b + 19, 2);
    push_exp(K_CORE, b + 19, 1);
    wait_to(b + 2);
    soft_rst_i = 1'b0;
    wait_to(b + 20);
    mode_i = 1'b1;
    wait_to(b + 25);

    // Free-run N=3, then N changed to 7 in the middle of a period.
    b = cyc;
    div_sel_i = 8'd3;
    mode_i = 1'b0;
    for (int k = 0; k < 5; k++) push_exp(K_TICK, b + 5 + 4 * k, 1);
    wait_to(b + 22);
    div_sel_i = 8'd7;
    for (int k = 0; k < 4; k++) push_exp(K_TICK, b + 25 + 8 * k, 1);
    wait_to(b + 50);
    mode_i = 1'b1;
    wait_to(b + 55);

    // N=0 ticks every cycle; a 0->1->0 mode toggle blanks two cycles.
    b = cyc;
    div_sel_i = 8'd0;
    mode_i = 1'b0;
    for (int k = 2; k <= 9; k++) push_exp(K_TICK, b + k, 1);
    wait_to(b + 9);
    mode_i = 1'b1;
    wait_to(b + 10);
    mode_i = 1'b0;
    for (int k = 12; k <= 15; k++) push_exp(K_TICK, b + k, 1);
    wait_to(b + 15);
    mode_i = 1'b1;
    wait_to(b + 20);

    // N=255 gives a 256-cycle period.
    b = cyc;
    div_sel_i = 8'd255;
    mode_i = 1'b0;
    push_exp(K_TICK, b + 257, 1);
    push_exp(K_TICK, b + 513, 1);
    wait_to(b + 514);
    mode_i = 1'b1;
    wait_to(b + 520);

    // Single-step: bouncing press gives one tick, release gives none.
    b = cyc;
    step_btn_ni = 1'b0;
    wait_to(b + 1);
    step_btn_ni = 1'b1;
    wait_to(b + 2);
    step_btn_ni = 1'b0;
    push_exp(K_TICK, b + 9, 1);
    wait_to(b + 12);
    step_btn_ni = 1'b1;
    wait_to(b + 30);

    // Press coinciding with a soft reset in RUN: press dropped, 16-cycle stretch.
    b = cyc;
    step_btn_ni = 1'b0;
    e1 = b + 7;
    push_exp(K_STATE, e1, 1);
    push_exp(K_CORE, e1, 0);
    for (int k = 1; k <= 16; k++) push_exp(K_TICK, e1 + k, 1);
    push_exp(K_STATE, e1 + 16, 2);
    push_exp(K_CORE, e1 + 16, 1);
    wait_to(b + 4);
    soft_rst_i = 1'b1;
    wait_to(b + 10);
    soft_rst_i = 1'b0;
    wait_to(b + 12);
    step_btn_ni = 1'b1;
    wait_to(e1 + 25);

    // Second soft pulse mid-stretch restarts the stretch count.
    b = cyc;
    soft_rst_i = 1'b1;
    e1 = b + 3;
    e2 = b + 11;
    push_exp(K_STATE, e1, 1);
    push_exp(K_CORE, e1, 0);
    for (int k = e1 + 1; k <= e2 + 16; k++) push_exp(K_TICK, k, 1);
    push_exp(K_STATE, e2 + 16, 2);
    push_exp(K_CORE, e2 + 16, 1);
    wait_to(b + 2);
    soft_rst_i = 1'b0;
    wait_to(b + 8);
    soft_rst_i = 1'b1;
    wait_to(b + 10);
    soft_rst_i = 1'b0;
    wait_to(e2 + 22);

    // Asynchronous reset while a tick is being driven, then free-run bring-up.
    b = cyc;
    div_sel_i = 8'd7;
    mode_i = 1'b0;
    push_exp(K_TICK, b + 9, 1);
    push_exp(K_STATE, b + 17, 0);
    push_exp(K_CORE, b + 17, 0);
    wait_to(b + 17);
    chk("tick_before_async_rst", int'(tick_o), 1);
    rst_i = 1'b1;
    #1;
    chk("async_rst_tick", int'(tick_o), 0);
    chk("async_rst_core_rst_n", int'(core_rst_no), 0);
    chk("async_rst_state", int'(state_o), 0);
    wait_to(b + 20);
    b = cyc;
    rst_i = 1'b0;
    push_exp(K_STATE, b + 3, 1);
    push_exp(K_TICK, b + 11, 1);
    push_exp(K_TICK, b + 19, 1);
    push_exp(K_STATE, b + 19, 2);
    push_exp(K_CORE, b + 19, 1);
    wait_to(b + 20);
    mode_i = 1'b1;
    wait_to(b + 30);

    chk("events_outstanding", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
